// File: rtl/regslv_access_pkg.sv
// Shared encodings, FSM state type and stride helper for the regslv access bank.
package regslv_access_pkg;

    localparam logic [1:0] RD_NA    = 2'd0;
    localparam logic [1:0] RD_RCLR  = 2'd1;
    localparam logic [1:0] RD_RSET  = 2'd2;
    localparam logic [1:0] RD_NA_3  = 2'd3;

    localparam logic [1:0] WR_RW    = 2'd0;
    localparam logic [1:0] WR_RO    = 2'd1;
    localparam logic [1:0] WR_WOCLR = 2'd2;
    localparam logic [1:0] WR_WOSET = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ACK  = 2'd2
    } fsm_state_e;

    // Number of byte-offset bits covered by one register (bytes per register is a power of two).
    function automatic int stride_log2(input int bytes);
        int n;
        n = 0;
        while ((32'sd1 <<< n) < bytes) n++;
        return n;
    endfunction

endpackage

// File: rtl/regslv_access_field.sv
// One bank register: reset value, soft reset, hardware load and software side effects.
module regslv_access_field
    import regslv_access_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [1:0]            RD_MODE    = 2'd0,
    parameter logic [1:0]            WR_MODE    = 2'd0,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = {DATA_WIDTH{1'b0}}
) (
    input  logic                  fsm_clk,
    input  logic                  fsm_rstn,
    input  logic                  soft_rst,
    input  logic                  sw_wr,
    input  logic                  sw_rd,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  hw_pulse,
    input  logic [DATA_WIDTH-1:0] hw_next_value,
    output logic [DATA_WIDTH-1:0] value
);

    logic [DATA_WIDTH-1:0] value_r;
    logic [DATA_WIDTH-1:0] value_n_s;

    // Next value: soft reset beats hardware load, which beats any software side effect.
    always_comb begin
        value_n_s = value_r;
        if (soft_rst) begin
            value_n_s = RST_VAL;
        end else if (hw_pulse) begin
            value_n_s = hw_next_value;
        end else if (sw_wr) begin
            case (WR_MODE)
                WR_RW:    value_n_s = wr_data;
                WR_RO:    value_n_s = value_r;
                WR_WOCLR: value_n_s = value_r & ~wr_data;
                WR_WOSET: value_n_s = value_r | wr_data;
                default:  value_n_s = value_r;
            endcase
        end else if (sw_rd) begin
            case (RD_MODE)
                RD_RCLR: value_n_s = {DATA_WIDTH{1'b0}};
                RD_RSET: value_n_s = {DATA_WIDTH{1'b1}};
                default: value_n_s = value_r;
            endcase
        end else begin
            value_n_s = value_r;
        end
    end

    // Register flop.
    always_ff @(posedge fsm_clk or negedge fsm_rstn) begin
        if (!fsm_rstn) value_r <= RST_VAL;
        else           value_r <= value_n_s;
    end

    assign value = value_r;

endmodule

// File: rtl/regslv_access_bank.sv
// Register-slave bank of REG_NUM fields behind the req_vld/ack_vld native interface.
// Define REGSLV_ACCESS_BANK_ADDR_CHK_EN to treat addresses with nonzero low offset bits as unmapped.
module regslv_access_bank
    import regslv_access_pkg::*;
#(
    parameter int                            ADDR_WIDTH = 64,
    parameter int                            DATA_WIDTH = 32,
    parameter int                            REG_NUM    = 3,
    parameter logic [ADDR_WIDTH-1:0]         BASE_ADDR  = {ADDR_WIDTH{1'b0}},
    parameter logic [2*REG_NUM-1:0]          RD_MODE    = {(2*REG_NUM){1'b0}},
    parameter logic [2*REG_NUM-1:0]          WR_MODE    = {(2*REG_NUM){1'b0}},
    parameter logic [REG_NUM*DATA_WIDTH-1:0] RST_VAL    = {(REG_NUM*DATA_WIDTH){1'b0}}
) (
    input  logic                          fsm_clk,
    input  logic                          fsm_rstn,
    input  logic                          soft_rst,
    output logic                          soft_rst_o,
    input  logic                          req_vld,
    input  logic                          wr_en,
    input  logic                          rd_en,
    input  logic [ADDR_WIDTH-1:0]         addr,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          ack_vld,
    output logic [DATA_WIDTH-1:0]         rd_data,
    input  logic [REG_NUM*DATA_WIDTH-1:0] hw_next_value,
    input  logic [REG_NUM-1:0]            hw_pulse,
    output logic [REG_NUM*DATA_WIDTH-1:0] hw_curr_value
);

    localparam int STRIDE_LOG2 = stride_log2(DATA_WIDTH / 8);
`ifdef REGSLV_ACCESS_BANK_ADDR_CHK_EN
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK =
        (ADDR_WIDTH'(1'b1) << STRIDE_LOG2) - ADDR_WIDTH'(1'b1);
`endif

    fsm_state_e            state_r, state_n_s;
    logic [ADDR_WIDTH-1:0] addr_r, off_s, idx_s;
    logic                  wr_en_r, rd_en_r;
    logic [DATA_WIDTH-1:0] wr_data_r, rd_mux_s, rd_data_r;
    logic                  ack_r, soft_rst_o_r, mapped_s, exec_s;
    logic [REG_NUM-1:0]    sw_wr_s, sw_rd_s;
    logic [DATA_WIDTH-1:0] cur_s [REG_NUM];

    // FSM state register.
    always_ff @(posedge fsm_clk or negedge fsm_rstn) begin
        if (!fsm_rstn) state_r <= ST_IDLE;
        else           state_r <= state_n_s;
    end

    // FSM next state: one access takes IDLE -> EXEC -> ACK.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_vld) state_n_s = ST_EXEC;
                else         state_n_s = ST_IDLE;
            end
            ST_EXEC: state_n_s = ST_ACK;
            ST_ACK:  state_n_s = ST_IDLE;
            default: state_n_s = ST_IDLE;
        endcase
    end

    // Request capture; requests arriving outside IDLE are ignored.
    always_ff @(posedge fsm_clk or negedge fsm_rstn) begin
        if (!fsm_rstn) begin
            addr_r    <= {ADDR_WIDTH{1'b0}};
            wr_en_r   <= 1'b0;
            rd_en_r   <= 1'b0;
            wr_data_r <= {DATA_WIDTH{1'b0}};
        end else if ((state_r == ST_IDLE) && req_vld) begin
            addr_r    <= addr;
            wr_en_r   <= wr_en;
            rd_en_r   <= rd_en;
            wr_data_r <= wr_data;
        end
    end

    // Address decode of the latched request.
    always_comb begin
        off_s    = addr_r - BASE_ADDR;
        idx_s    = off_s >> STRIDE_LOG2;
        mapped_s = (addr_r >= BASE_ADDR) && (idx_s < ADDR_WIDTH'(REG_NUM));
`ifdef REGSLV_ACCESS_BANK_ADDR_CHK_EN
        mapped_s = mapped_s && ((off_s & LOW_MASK) == {ADDR_WIDTH{1'b0}});
`endif
        exec_s   = (state_r == ST_EXEC);
    end

    for (genvar i = 0; i < REG_NUM; i++) begin : g_field
        // A request with both enables counts as a write only.
        assign sw_wr_s[i] = exec_s && mapped_s && wr_en_r && (idx_s == ADDR_WIDTH'(i));
        assign sw_rd_s[i] = exec_s && mapped_s && rd_en_r && !wr_en_r && (idx_s == ADDR_WIDTH'(i));

        regslv_access_field #(
            .DATA_WIDTH (DATA_WIDTH),
            .RD_MODE    (RD_MODE[2*i +: 2]),
            .WR_MODE    (WR_MODE[2*i +: 2]),
            .RST_VAL    (RST_VAL[i*DATA_WIDTH +: DATA_WIDTH])
        ) u_field (
            .fsm_clk       (fsm_clk),
            .fsm_rstn      (fsm_rstn),
            .soft_rst      (soft_rst),
            .sw_wr         (sw_wr_s[i]),
            .sw_rd         (sw_rd_s[i]),
            .wr_data       (wr_data_r),
            .hw_pulse      (hw_pulse[i]),
            .hw_next_value (hw_next_value[i*DATA_WIDTH +: DATA_WIDTH]),
            .value         (cur_s[i])
        );

        assign hw_curr_value[i*DATA_WIDTH +: DATA_WIDTH] = cur_s[i];
    end

    // Read mux: pre-edge value of the single selected register, zero otherwise.
    always_comb begin
        rd_mux_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < REG_NUM; i++) begin
            rd_mux_s = rd_mux_s | (cur_s[i] & {DATA_WIDTH{sw_rd_s[i]}});
        end
    end

    // Registered outputs: ack pulse, held read data, delayed soft reset.
    always_ff @(posedge fsm_clk or negedge fsm_rstn) begin
        if (!fsm_rstn) begin
            ack_r        <= 1'b0;
            rd_data_r    <= {DATA_WIDTH{1'b0}};
            soft_rst_o_r <= 1'b0;
        end else begin
            ack_r        <= exec_s;
            soft_rst_o_r <= soft_rst;
            if (exec_s) rd_data_r <= rd_mux_s;
            else        rd_data_r <= rd_data_r;
        end
    end

    assign ack_vld    = ack_r;
    assign rd_data    = rd_data_r;
    assign soft_rst_o = soft_rst_o_r;

endmodule

// File: tb/tb_regslv_access_bank.sv
// Directed self-checking bench for regslv_access_bank (main bank plus a WOCLR/WOSET bank).
module tb_regslv_access_bank;

    localparam logic [5:0]  RD_M     = {2'd2, 2'd1, 2'd0};
    localparam logic [5:0]  WR_M     = 6'd0;
    localparam logic [95:0] RST_V    = {32'h33333333, 32'h22222222, 32'h11111111};
    localparam logic [5:0]  WR_M_WO  = {2'd0, 2'd3, 2'd2};
    localparam logic [95:0] RST_V_WO = {32'h00000000, 32'h0F0F0F0F, 32'h0F0F0F0F};

    logic        clk = 1'b0, rst_n = 1'b1, soft_rst = 1'b0;
    logic        req_vld = 1'b0, req_vld_wo = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [63:0] addr = 64'd0;
    logic [31:0] wr_data = 32'd0;
    logic [95:0] hw_next_value = 96'd0;
    logic [2:0]  hw_pulse = 3'd0, hw_pulse_wo = 3'd0;
    logic        ack_vld, ack_wo, soft_rst_o, soft_rst_o_wo;
    logic [31:0] rd_data, rd_data_wo;
    logic [95:0] hw_curr_value, hw_curr_wo;

    int          n_cmp = 0, n_err = 0, last_lat;
    logic [31:0] last_rd;
    logic [95:0] snap;

    always #5 clk = ~clk;

    regslv_access_bank #(.ADDR_WIDTH(64), .DATA_WIDTH(32), .REG_NUM(3), .BASE_ADDR(64'd0),
        .RD_MODE(RD_M), .WR_MODE(WR_M), .RST_VAL(RST_V)) u_dut (
        .fsm_clk(clk), .fsm_rstn(rst_n), .soft_rst(soft_rst), .soft_rst_o(soft_rst_o),
        .req_vld(req_vld), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data),
        .ack_vld(ack_vld), .rd_data(rd_data), .hw_next_value(hw_next_value),
        .hw_pulse(hw_pulse), .hw_curr_value(hw_curr_value));

    regslv_access_bank #(.ADDR_WIDTH(64), .DATA_WIDTH(32), .REG_NUM(3), .BASE_ADDR(64'd0),
        .RD_MODE(6'd0), .WR_MODE(WR_M_WO), .RST_VAL(RST_V_WO)) u_dut_wo (
        .fsm_clk(clk), .fsm_rstn(rst_n), .soft_rst(soft_rst), .soft_rst_o(soft_rst_o_wo),
        .req_vld(req_vld_wo), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data),
        .ack_vld(ack_wo), .rd_data(rd_data_wo), .hw_next_value(hw_next_value),
        .hw_pulse(hw_pulse_wo), .hw_curr_value(hw_curr_wo));

    function automatic logic [31:0] reg_of(input logic [95:0] v, input int i);
        return v[i*32 +: 32];
    endfunction

    // One request pulse, then six sampled cycles; records ack latency (0 = none) and rd_data.
    task automatic access(input bit wo, input logic w, input logic r,
                          input logic [63:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en = w; rd_en = r; addr = a; wr_data = d;
        if (wo) req_vld_wo = 1'b1;
        else    req_vld    = 1'b1;
        last_lat = 0;
        last_rd  = 32'd0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            req_vld = 1'b0; req_vld_wo = 1'b0;
            if (last_lat == 0 && (wo ? ack_wo : ack_vld)) begin
                last_lat = k;
                last_rd  = wo ? rd_data_wo : rd_data;
            end
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #10;
        n_cmp++; if (ack_vld !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", ack_vld); end
        n_cmp++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        n_cmp++; if (soft_rst_o !== 1'b0) begin n_err++; $display("FAIL reset_soft_rst_o: got %b want 0", soft_rst_o); end
        n_cmp++; if (hw_curr_value !== RST_V) begin n_err++; $display("FAIL reset_hw_curr: got %h want %h", hw_curr_value, RST_V); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rw_modes();
        logic [31:0] after_rd [3];
        after_rd[0] = 32'h12345678; after_rd[1] = 32'h00000000; after_rd[2] = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            access(1'b0, 1'b1, 1'b0, 64'(4 * i), 32'h12345678);
            n_cmp++; if (last_lat !== 2) begin n_err++; $display("FAIL wr_latency[%0d]: got %0d want 2", i, last_lat); end
            n_cmp++; if (reg_of(hw_curr_value, i) !== 32'h12345678) begin n_err++; $display("FAIL wr_value[%0d]: got %h want 12345678", i, reg_of(hw_curr_value, i)); end
            access(1'b0, 1'b0, 1'b1, 64'(4 * i), 32'd0);
            n_cmp++; if (last_rd !== 32'h12345678) begin n_err++; $display("FAIL rd_data[%0d]: got %h want 12345678", i, last_rd); end
            n_cmp++; if (reg_of(hw_curr_value, i) !== after_rd[i]) begin n_err++; $display("FAIL rd_effect[%0d]: got %h want %h", i, reg_of(hw_curr_value, i), after_rd[i]); end
            access(1'b0, 1'b1, 1'b0, 64'(4 * i), 32'hFFFFFFFF);
            n_cmp++; if (reg_of(hw_curr_value, i) !== 32'hFFFFFFFF) begin n_err++; $display("FAIL wr_ones[%0d]: got %h want ffffffff", i, reg_of(hw_curr_value, i)); end
        end
    endtask

    task automatic test_wo_modes();
        access(1'b1, 1'b1, 1'b0, 64'd0, 32'h000000FF);
        n_cmp++; if (reg_of(hw_curr_wo, 0) !== 32'h0F0F0F00) begin n_err++; $display("FAIL woclr: got %h want 0f0f0f00", reg_of(hw_curr_wo, 0)); end
        access(1'b1, 1'b1, 1'b0, 64'd4, 32'h000000FF);
        n_cmp++; if (reg_of(hw_curr_wo, 1) !== 32'h0F0F0FFF) begin n_err++; $display("FAIL woset: got %h want 0f0f0fff", reg_of(hw_curr_wo, 1)); end
        n_cmp++; if (reg_of(hw_curr_wo, 0) !== 32'h0F0F0F00) begin n_err++; $display("FAIL woclr_keep: got %h want 0f0f0f00", reg_of(hw_curr_wo, 0)); end
    endtask

    task automatic test_hw_priority();
        access(1'b0, 1'b1, 1'b0, 64'd4, 32'hDEADBEEF);
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b1; addr = 64'd4; req_vld = 1'b1;
        @(negedge clk);
        req_vld = 1'b0; hw_pulse = 3'b010; hw_next_value[63:32] = 32'hA5A5A5A5;
        @(negedge clk);
        hw_pulse = 3'b000;
        n_cmp++; if (ack_vld !== 1'b1) begin n_err++; $display("FAIL hw_prio_ack: got %b want 1", ack_vld); end
        n_cmp++; if (rd_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL hw_prio_rd: got %h want deadbeef", rd_data); end
        n_cmp++; if (reg_of(hw_curr_value, 1) !== 32'hA5A5A5A5) begin n_err++; $display("FAIL hw_prio_val: got %h want a5a5a5a5", reg_of(hw_curr_value, 1)); end
        @(negedge clk);
        hw_pulse = 3'b001; hw_next_value[31:0] = 32'h5A5A0000;
        @(negedge clk);
        hw_pulse = 3'b000;
        n_cmp++; if (reg_of(hw_curr_value, 0) !== 32'h5A5A0000) begin n_err++; $display("FAIL hw_idle_load: got %h want 5a5a0000", reg_of(hw_curr_value, 0)); end
    endtask

    task automatic test_both_neither();
        access(1'b0, 1'b1, 1'b1, 64'd8, 32'hCAFEF00D);
        n_cmp++; if (last_lat !== 2) begin n_err++; $display("FAIL both_latency: got %0d want 2", last_lat); end
        n_cmp++; if (last_rd !== 32'd0) begin n_err++; $display("FAIL both_rd: got %h want 0", last_rd); end
        n_cmp++; if (reg_of(hw_curr_value, 2) !== 32'hCAFEF00D) begin n_err++; $display("FAIL both_wr: got %h want cafef00d", reg_of(hw_curr_value, 2)); end
        access(1'b0, 1'b0, 1'b1, 64'd0, 32'd0);
        snap = hw_curr_value;
        access(1'b0, 1'b0, 1'b0, 64'd4, 32'hFFFFFFFF);
        n_cmp++; if (last_lat !== 2) begin n_err++; $display("FAIL neither_latency: got %0d want 2", last_lat); end
        n_cmp++; if (last_rd !== 32'd0) begin n_err++; $display("FAIL neither_rd: got %h want 0", last_rd); end
        n_cmp++; if (hw_curr_value !== snap) begin n_err++; $display("FAIL neither_regs: got %h want %h", hw_curr_value, snap); end
    endtask

    task automatic test_unmapped();
        access(1'b0, 1'b0, 1'b1, 64'd0, 32'd0);
        n_cmp++; if (last_rd !== 32'h5A5A0000) begin n_err++; $display("FAIL pre_unmapped_rd: got %h want 5a5a0000", last_rd); end
        access(1'b0, 1'b0, 1'b1, 64'h0C, 32'd0);
        n_cmp++; if (last_lat !== 2) begin n_err++; $display("FAIL unmapped_latency: got %0d want 2", last_lat); end
        n_cmp++; if (last_rd !== 32'd0) begin n_err++; $display("FAIL unmapped_rd: got %h want 0", last_rd); end
        snap = hw_curr_value;
        access(1'b0, 1'b1, 1'b0, 64'h0C, 32'h12121212);
        n_cmp++; if (hw_curr_value !== snap) begin n_err++; $display("FAIL unmapped_wr: got %h want %h", hw_curr_value, snap); end
    endtask

    task automatic test_addr_align();
        logic [31:0] exp;
`ifdef REGSLV_ACCESS_BANK_ADDR_CHK_EN
        exp = reg_of(hw_curr_value, 0);
`else
        exp = 32'h77777777;
`endif
        access(1'b0, 1'b1, 1'b0, 64'h02, 32'h77777777);
        n_cmp++; if (reg_of(hw_curr_value, 0) !== exp) begin n_err++; $display("FAIL misaligned_wr: got %h want %h", reg_of(hw_curr_value, 0), exp); end
    endtask

    task automatic test_soft_rst();
        @(negedge clk);
        wr_en = 1'b1; rd_en = 1'b0; addr = 64'd0; wr_data = 32'h99999999; req_vld = 1'b1;
        @(negedge clk);
        req_vld = 1'b0; soft_rst = 1'b1;
        @(negedge clk);
        soft_rst = 1'b0;
        n_cmp++; if (ack_vld !== 1'b1) begin n_err++; $display("FAIL srst_ack: got %b want 1", ack_vld); end
        n_cmp++; if (hw_curr_value !== RST_V) begin n_err++; $display("FAIL srst_regs: got %h want %h", hw_curr_value, RST_V); end
        n_cmp++; if (soft_rst_o !== 1'b1) begin n_err++; $display("FAIL srst_o_high: got %b want 1", soft_rst_o); end
        @(negedge clk);
        n_cmp++; if (soft_rst_o !== 1'b0) begin n_err++; $display("FAIL srst_o_low: got %b want 0", soft_rst_o); end
    endtask

    task automatic test_async_reset();
        bit seen;
        access(1'b0, 1'b1, 1'b0, 64'd0, 32'h55555555);
        n_cmp++; if (reg_of(hw_curr_value, 0) !== 32'h55555555) begin n_err++; $display("FAIL pre_arst_wr: got %h want 55555555", reg_of(hw_curr_value, 0)); end
        @(negedge clk);
        wr_en = 1'b1; rd_en = 1'b0; addr = 64'd4; wr_data = 32'h44444444; req_vld = 1'b1;
        @(negedge clk);
        req_vld = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (ack_vld) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL arst_no_ack: got %b want 0", seen); end
        n_cmp++; if (hw_curr_value !== RST_V) begin n_err++; $display("FAIL arst_regs: got %h want %h", hw_curr_value, RST_V); end
        n_cmp++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL arst_rd_data: got %h want 0", rd_data); end
    endtask

    initial begin
        test_reset();
        test_rw_modes();
        test_wo_modes();
        test_hw_priority();
        test_both_neither();
        test_unmapped();
        test_addr_align();
        test_soft_rst();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
